// File: rtl/rename_freelist_ctrl.sv
// Rename/recovery controller: owns the physical-tag free list and drives both map tables.
// Optional free-list consistency checking (fl_err) is built when RENAME_FREELIST_CHECK_EN is defined.
module rename_freelist_ctrl #(
  parameter int ARCHFILE_SIZE = 32,
  parameter int PHYSFILE_SIZE = 256,
  localparam int AW = $clog2(ARCHFILE_SIZE),
  localparam int TW = $clog2(PHYSFILE_SIZE)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          ren_valid,
  output logic          ren_ready,
  input  logic [AW-1:0] ren_rd,
  output logic [TW-1:0] ren_phys,
  input  logic          cmt_valid,
  output logic          cmt_ready,
  input  logic [AW-1:0] cmt_rd,
  input  logic [TW-1:0] cmt_newphys,
  input  logic [TW-1:0] cmt_oldphys,
  input  logic          flush_req,
  output logic          map_update,
  output logic [AW-1:0] map_wr,
  output logic [TW-1:0] map_wr_phys,
  output logic          map_rollback,
  output logic          cmt_update,
  output logic [AW-1:0] cmt_wr,
  output logic [TW-1:0] cmt_wr_phys,
  output logic [TW:0]   free_count,
  output logic          busy
`ifdef RENAME_FREELIST_CHECK_EN
  ,
  output logic          fl_err
`endif
);

  typedef enum logic [1:0] {RUN, RB_ISSUE, RB_WAIT} state_t;

  state_t                            state_reg;
  logic [PHYSFILE_SIZE-1:0][TW-1:0]  fifo_reg;
  logic [TW-1:0]                     spec_head_reg;
  logic [TW-1:0]                     commit_head_reg;
  logic [TW-1:0]                     tail_reg;
  logic [TW:0]                       free_count_reg;

  logic ren_fire, cmt_fire, pop, cmt_adv, push;

  // Outputs are forced low while rst is asserted, including the combinational handshakes.
  assign ren_ready = rst && (state_reg == RUN) && (free_count_reg != '0) && !flush_req;
  assign cmt_ready = rst && (state_reg != RB_ISSUE);

  assign ren_fire = ren_valid && ren_ready;
  assign pop      = ren_fire && (ren_rd != '0);
  assign cmt_fire = cmt_valid && cmt_ready;
  assign cmt_adv  = cmt_fire && (cmt_rd != '0);
  assign push     = cmt_adv && (cmt_oldphys != '0);

  assign ren_phys     = pop ? fifo_reg[spec_head_reg] : '0;
  assign map_update   = pop;
  assign map_wr       = pop ? ren_rd : '0;
  assign map_wr_phys  = ren_phys;

  assign cmt_update   = cmt_adv;
  assign cmt_wr       = cmt_adv ? cmt_rd : '0;
  assign cmt_wr_phys  = cmt_adv ? cmt_newphys : '0;

  assign map_rollback = rst && (state_reg == RB_ISSUE);
  assign busy         = rst && (state_reg != RUN);
  assign free_count   = rst ? free_count_reg : '0;

  // Slot i initially holds tag i+1; the last slot wraps to 0 and sits beyond the tail.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < PHYSFILE_SIZE; i++) begin
        fifo_reg[i] <= TW'(i + 1);
      end
    end else if (push) begin
      fifo_reg[tail_reg] <= cmt_oldphys;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_reg       <= RUN;
      spec_head_reg   <= '0;
      commit_head_reg <= '0;
      tail_reg        <= TW'(PHYSFILE_SIZE - 1);
      free_count_reg  <= (TW+1)'(PHYSFILE_SIZE - 1);
    end else begin
      if (state_reg == RB_ISSUE) begin
        spec_head_reg <= commit_head_reg;
      end else if (pop) begin
        spec_head_reg <= spec_head_reg + 1'b1;
      end
      if (cmt_adv) begin
        commit_head_reg <= commit_head_reg + 1'b1;
      end
      if (push) begin
        tail_reg <= tail_reg + 1'b1;
      end

      // Rollback returns every in-flight tag: free space becomes tail - commit_head.
      if (state_reg == RB_ISSUE) begin
        free_count_reg <= {1'b0, tail_reg - commit_head_reg};
      end else begin
        case ({push, pop})
          2'b10:   free_count_reg <= free_count_reg + 1'b1;
          2'b01:   free_count_reg <= free_count_reg - 1'b1;
          default: free_count_reg <= free_count_reg;
        endcase
      end

      case (state_reg)
        RUN:      if (flush_req) state_reg <= RB_ISSUE;
        RB_ISSUE: state_reg <= RB_WAIT;
        RB_WAIT:  state_reg <= RUN;
        default:  state_reg <= RUN;
      endcase
    end
  end

`ifdef RENAME_FREELIST_CHECK_EN
  logic [TW-1:0] occupancy;
  logic          err_now;

  assign occupancy = tail_reg - commit_head_reg;
  assign err_now   = (push && (occupancy == TW'(PHYSFILE_SIZE - 1)))
                  || (cmt_adv && (commit_head_reg == spec_head_reg))
                  || (cmt_fire && (cmt_rd == '0) && (cmt_newphys != '0));

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      fl_err <= 1'b0;
    end else if (err_now) begin
      fl_err <= 1'b1;
    end
  end
`endif

endmodule

// File: doc/rename_freelist_ctrl.md
Name: rename_freelist_ctrl

Overview:
- Rename/recovery controller that drives the speculative and non-speculative arch-to-phys map tables.
- Owns the physical-register free list as a circular FIFO with a speculative head, a commit head and a tail.
- Allocates a tag per renamed destination and issues the map-table updates.
- Returns old tags at commit; on flush, sequences the map rollback and restores the free list.

Parameters:
- ARCHFILE_SIZE, 32, number of architectural registers; AW = $clog2(ARCHFILE_SIZE)
- PHYSFILE_SIZE, 256, number of physical registers, power of two; TW = $clog2(PHYSFILE_SIZE)

Ports:
- clk  in  1  clock
- rst  in  1  asynchronous, active-low reset
- ren_valid  in  1  rename request
- ren_ready  out  1  request accepted when ren_valid && ren_ready
- ren_rd  in  AW  destination arch reg; 0 = no destination
- ren_phys  out  TW  allocated tag, valid in the handshake cycle; 0 when ren_rd==0
- cmt_valid  in  1  commit of one instruction
- cmt_ready  out  1  commit accepted when cmt_valid && cmt_ready
- cmt_rd  in  AW  committed destination; 0 = none
- cmt_newphys  in  TW  tag allocated to cmt_rd
- cmt_oldphys  in  TW  previous mapping of cmt_rd, to be freed
- flush_req  in  1  mispredict/exception pulse
- map_update  out  1  speculative map-table write enable
- map_wr  out  AW  speculative map-table write index
- map_wr_phys  out  TW  speculative map-table write data
- map_rollback  out  1  speculative map-table loads the committed map this cycle
- cmt_update  out  1  committed map-table write enable
- cmt_wr  out  AW  committed map-table write index
- cmt_wr_phys  out  TW  committed map-table write data
- free_count  out  TW+1  speculative free entries (tail - spec_head)
- busy  out  1  high while not in RUN

Behaviour:
- Reset (rst low, async):
  - FIFO holds tags 1..PHYSFILE_SIZE-1; tag 0 is the shared initial mapping and is never allocated.
  - spec_head = commit_head = 0; tail = PHYSFILE_SIZE-1; free_count = PHYSFILE_SIZE-1; state = RUN.
  - All outputs 0 while in reset.
- Pointers are TW bits and wrap naturally. Counts are kept as separate TW+1-bit registers.
- FSM: RUN -> RB_ISSUE -> RB_WAIT -> RUN.
- RUN:
  - ren_ready = (free_count != 0), using the registered count only; no same-cycle bypass of frees.
  - cmt_ready = 1.
  - Accepted rename with ren_rd != 0:
    - ren_phys = fifo[spec_head]; map_update = 1, map_wr = ren_rd, map_wr_phys = ren_phys, all combinational in the same cycle.
    - spec_head advances by 1.
  - Accepted rename with ren_rd == 0: no pop, map_update = 0, ren_phys = 0.
  - Accepted commit with cmt_rd != 0:
    - cmt_update = 1, cmt_wr = cmt_rd, cmt_wr_phys = cmt_newphys.
    - commit_head advances by 1.
    - If cmt_oldphys != 0, write fifo[tail] = cmt_oldphys and advance tail.
  - A same-cycle allocate and free leaves free_count unchanged.
  - flush_req in RUN:
    - Any rename in that cycle is suppressed (ren_ready = 0); a commit in that cycle is still accepted.
    - Next state = RB_ISSUE.
- RB_ISSUE:
  - map_rollback = 1; ren_ready = 0; cmt_ready = 0, so the committed map is stable for the load.
  - spec_head <= commit_head, which already includes any commit accepted in the flush cycle.
  - free_count <= tail - commit_head, plus the effect of any tail advance in that edge.
  - Next state = RB_WAIT.
- RB_WAIT:
  - ren_ready = 0; cmt_ready = 1.
  - Next state = RUN.
- flush_req while busy is ignored; total flush penalty is 3 cycles before the next rename.
- Reset mid-rollback returns to the reset state; the map tables are reset by the same rst.
- busy = (state != RUN).

Optional Feature:
- Macro RENAME_FREELIST_CHECK_EN.
- With the macro defined:
  - Adds output fl_err (1 bit, sticky until reset).
  - fl_err sets on: a push when the list already holds PHYSFILE_SIZE-1 entries; a commit with cmt_rd != 0 while commit_head == spec_head (committing an unallocated tag); a commit with cmt_rd == 0 and cmt_newphys != 0.
  - The offending operation is still executed.
- Without the macro: no fl_err port and no checking logic.

Test Plan:
- Reset, rename rd=5 then rd=6 -> ren_phys=1 then 2; map_update/map_wr/map_wr_phys=(1,5,1),(1,6,2); free_count 255->253.
- 255 renames with rd=1 -> ren_ready=0 after the 255th, free_count=0; commit rd=1 old=0 new=1 -> free_count stays 0; commit rd=1 old=1 new=2 -> ren_ready=1 next cycle, next ren_phys=1.
- Rename rd=3 (tag 1) and commit rd=3 new=1 old=0 in the same cycle as rename rd=4 -> commit_head=1, spec_head=2, cmt_update=1 cmt_wr=3 cmt_wr_phys=1.
- After 4 renames and 1 commit, pulse flush_req -> map_rollback high exactly 1 cycle, ren_ready low 3 cycles, next ren_phys=2, free_count=254.
- Rename rd=0 -> ren_ready=1, ren_phys=0, map_update=0, free_count unchanged; rst low during RB_WAIT -> busy=0, free_count=255.
